branch_predictor: RTL and testbench

Parametrised branch predictor combining a branch target buffer (BTB) with per-entry saturating counters, placed in the IF stage of the pipelined RISC-V core. It replaces the fixed predict-not-taken/flush-on-taken scheme. The IF stage looks up the current PC and gets a predicted next PC. The EX/MEM stage sends back the resolved outcome; the block updates its tables and raises a mispredict flag that drives the IF/ID and ID/EX flush.

---
 rtl/bp_pkg.sv | 49 ++++
 rtl/bp_entry_next.sv | 47 ++++
 rtl/branch_predictor.sv | 119 +++++++++++
 tb/tb_branch_predictor.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and helpers for the BTB + saturating-counter branch predictor.
// Helpers take run-time widths so any legal module parameterisation can use them.
package bp_pkg;

    localparam int BP_XLEN     = 64;
    localparam int BP_TAG_BITS = 10;
    localparam int BP_CTR_BITS = 2;

    // Counter thresholds for the default counter width: weakly not-taken / weakly taken.
    localparam logic [BP_CTR_BITS-1:0] WNT = BP_CTR_BITS'((1 << (BP_CTR_BITS - 1)) - 1);
    localparam logic [BP_CTR_BITS-1:0] WT  = BP_CTR_BITS'(1 << (BP_CTR_BITS - 1));

    // One table entry in the default configuration.
    typedef struct packed {
        logic                   valid;
        logic [BP_TAG_BITS-1:0] tag;
        logic [BP_XLEN-1:0]     target;
        logic [BP_CTR_BITS-1:0] ctr;
    } bp_entry_t;

    function automatic logic [31:0] ctr_wnt(input int bits);
        return (32'd1 << (bits - 1)) - 32'd1;
    endfunction

    function automatic logic [31:0] ctr_wt(input int bits);
        return 32'd1 << (bits - 1);
    endfunction

    // PCs are word aligned, so bits [1:0] never take part in indexing.
    function automatic logic [31:0] bp_index(input logic [63:0] pc, input int idx_bits);
        return 32'((pc >> 2) & ((64'd1 << idx_bits) - 64'd1));
    endfunction

    function automatic logic [31:0] bp_tag(input logic [63:0] pc, input int idx_bits,
                                           input int tag_bits);
        return 32'((pc >> (idx_bits + 2)) & ((64'd1 << tag_bits) - 64'd1));
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] ctr, input int bits);
        logic [7:0] max_val;
        max_val = 8'((16'd1 << bits) - 16'd1);
        return (ctr == max_val) ? ctr : ctr + 8'd1;
    endfunction

    function automatic logic [7:0] sat_dec(input logic [7:0] ctr);
        return (ctr == 8'd0) ? ctr : ctr - 8'd1;
    endfunction

endpackage

// File: rtl/bp_entry_next.sv
// Next-state of a single predictor entry given whether the resolving branch hit it
// and whether it was taken.
module bp_entry_next
    import bp_pkg::*;
#(
    parameter int XLEN     = BP_XLEN,
    parameter int TAG_BITS = BP_TAG_BITS,
    parameter int CTR_BITS = BP_CTR_BITS
) (
    input  logic                cur_valid,
    input  logic [TAG_BITS-1:0] cur_tag,
    input  logic [XLEN-1:0]     cur_target,
    input  logic [CTR_BITS-1:0] cur_ctr,
    input  logic                hit,
    input  logic                taken,
    input  logic [TAG_BITS-1:0] new_tag,
    input  logic [XLEN-1:0]     new_target,
    output logic                nxt_valid,
    output logic [TAG_BITS-1:0] nxt_tag,
    output logic [XLEN-1:0]     nxt_target,
    output logic [CTR_BITS-1:0] nxt_ctr
);

    localparam logic [CTR_BITS-1:0] CTR_WT = CTR_BITS'(ctr_wt(CTR_BITS));

    always_comb begin
        nxt_valid  = cur_valid;
        nxt_tag    = cur_tag;
        nxt_target = cur_target;
        nxt_ctr    = cur_ctr;
        if (hit) begin
            if (taken) begin
                nxt_ctr    = CTR_BITS'(sat_inc(8'(cur_ctr), CTR_BITS));
                nxt_target = new_target;
            end else begin
                nxt_ctr = CTR_BITS'(sat_dec(8'(cur_ctr)));
            end
        end else if (taken) begin
            // Allocation replaces whatever aliased into this slot.
            nxt_valid  = 1'b1;
            nxt_tag    = new_tag;
            nxt_target = new_target;
            nxt_ctr    = CTR_WT;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// IF-stage branch predictor: BTB with per-entry saturating counters.
// Optional global-history (gshare) indexing when BRANCH_PREDICTOR_GSHARE_EN is defined.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int XLEN      = BP_XLEN,
    parameter int ENTRIES   = 64,
    parameter int TAG_BITS  = BP_TAG_BITS,
    parameter int CTR_BITS  = BP_CTR_BITS,
    parameter int HIST_BITS = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [XLEN-1:0]      lkp_pc,
    output logic                 lkp_hit,
    output logic                 lkp_taken,
    output logic [XLEN-1:0]      lkp_next_pc,
    output logic [HIST_BITS-1:0] lkp_ghr,
    input  logic                 upd_valid,
    input  logic [XLEN-1:0]      upd_pc,
    input  logic                 upd_taken,
    input  logic [XLEN-1:0]      upd_target,
    input  logic                 upd_pred_taken,
    input  logic [XLEN-1:0]      upd_pred_target,
    input  logic [HIST_BITS-1:0] upd_ghr,
    output logic                 mispredict
);

    localparam int IDX = $clog2(ENTRIES);
    localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'(ctr_wnt(CTR_BITS));

    logic                valid_q  [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [XLEN-1:0]     target_q [ENTRIES];
    logic [CTR_BITS-1:0] ctr_q    [ENTRIES];

    logic [IDX-1:0]      lkp_pc_idx, upd_pc_idx, lkp_idx, upd_idx;
    logic [TAG_BITS-1:0] lkp_tag, upd_tag;
    logic                upd_hit;
    logic                nxt_valid;
    logic [TAG_BITS-1:0] nxt_tag;
    logic [XLEN-1:0]     nxt_target;
    logic [CTR_BITS-1:0] nxt_ctr;

    assign lkp_pc_idx = IDX'(bp_index(64'(lkp_pc), IDX));
    assign upd_pc_idx = IDX'(bp_index(64'(upd_pc), IDX));
    assign lkp_tag    = TAG_BITS'(bp_tag(64'(lkp_pc), IDX, TAG_BITS));
    assign upd_tag    = TAG_BITS'(bp_tag(64'(upd_pc), IDX, TAG_BITS));

`ifdef BRANCH_PREDICTOR_GSHARE_EN
    logic [HIST_BITS-1:0] ghr_q;

    // The update uses the history snapshot taken at lookup, not the live GHR.
    assign lkp_idx = lkp_pc_idx ^ IDX'(ghr_q);
    assign upd_idx = upd_pc_idx ^ IDX'(upd_ghr);
    assign lkp_ghr = ghr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ghr_q <= '0;
        end else if (upd_valid) begin
            ghr_q <= HIST_BITS'({ghr_q, upd_taken});
        end
    end
`else
    logic unused_upd_ghr;

    assign lkp_idx        = lkp_pc_idx;
    assign upd_idx        = upd_pc_idx;
    assign lkp_ghr        = '0;
    assign unused_upd_ghr = ^upd_ghr;
`endif

    assign lkp_hit     = valid_q[lkp_idx] && (tag_q[lkp_idx] == lkp_tag);
    assign lkp_taken   = lkp_hit && ctr_q[lkp_idx][CTR_BITS-1];
    assign lkp_next_pc = lkp_taken ? target_q[lkp_idx] : lkp_pc + XLEN'(4);

    assign upd_hit    = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign mispredict = upd_valid &&
                        ((upd_pred_taken != upd_taken) ||
                         (upd_taken && (upd_pred_target != upd_target)));

    bp_entry_next #(
        .XLEN     (XLEN),
        .TAG_BITS (TAG_BITS),
        .CTR_BITS (CTR_BITS)
    ) u_entry_next (
        .cur_valid  (valid_q[upd_idx]),
        .cur_tag    (tag_q[upd_idx]),
        .cur_target (target_q[upd_idx]),
        .cur_ctr    (ctr_q[upd_idx]),
        .hit        (upd_hit),
        .taken      (upd_taken),
        .new_tag    (upd_tag),
        .new_target (upd_target),
        .nxt_valid  (nxt_valid),
        .nxt_tag    (nxt_tag),
        .nxt_target (nxt_target),
        .nxt_ctr    (nxt_ctr)
    );

    // Writing back the unchanged entry on a not-taken miss keeps the write port simple.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_WNT;
            end
        end else if (upd_valid) begin
            valid_q[upd_idx]  <= nxt_valid;
            tag_q[upd_idx]    <= nxt_tag;
            target_q[upd_idx] <= nxt_target;
            ctr_q[upd_idx]    <= nxt_ctr;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: a driver issues lookups/updates and queues the
// expected lookup/mispredict response from a table-level model; a monitor compares.
module tb_branch_predictor;

    localparam int XLEN      = 64;
    localparam int ENTRIES   = 64;
    localparam int TAG_BITS  = 10;
    localparam int CTR_BITS  = 2;
    localparam int HIST_BITS = 6;
    localparam int EXP_W     = 2 + XLEN + 1 + HIST_BITS;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic [XLEN-1:0]      lkp_pc = '0;
    logic                 lkp_hit, lkp_taken, mispredict;
    logic [XLEN-1:0]      lkp_next_pc;
    logic [HIST_BITS-1:0] lkp_ghr;
    logic                 upd_valid = 1'b0;
    logic [XLEN-1:0]      upd_pc = '0;
    logic                 upd_taken = 1'b0;
    logic [XLEN-1:0]      upd_target = '0;
    logic                 upd_pred_taken = 1'b0;
    logic [XLEN-1:0]      upd_pred_target = '0;
    logic [HIST_BITS-1:0] upd_ghr = '0;

    always #5 clk = ~clk;

    branch_predictor #(
        .XLEN(XLEN), .ENTRIES(ENTRIES), .TAG_BITS(TAG_BITS),
        .CTR_BITS(CTR_BITS), .HIST_BITS(HIST_BITS)
    ) dut (
        .clk(clk), .reset(reset),
        .lkp_pc(lkp_pc), .lkp_hit(lkp_hit), .lkp_taken(lkp_taken),
        .lkp_next_pc(lkp_next_pc), .lkp_ghr(lkp_ghr),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target), .upd_ghr(upd_ghr),
        .mispredict(mispredict)
    );

    // Reference model: a table of entries with integer counters.
    bit          m_valid  [ENTRIES];
    int unsigned m_tag    [ENTRIES];
    logic [63:0] m_target [ENTRIES];
    int          m_ctr    [ENTRIES];
    int unsigned m_ghr;

    logic [EXP_W-1:0] exp_q[$];
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned m_index(input logic [63:0] pc, input int unsigned ghr);
        int unsigned i;
        i = int'((pc / 4) % ENTRIES);
`ifdef BRANCH_PREDICTOR_GSHARE_EN
        i = i ^ ghr;
`else
        if (ghr > 32'hFFFF) i = i;
`endif
        return i;
    endfunction

    function automatic int unsigned m_tag_of(input logic [63:0] pc);
        return int'((pc / (4 * ENTRIES)) % (1 << TAG_BITS));
    endfunction

    task automatic m_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i]  = 1'b0;
            m_tag[i]    = 0;
            m_target[i] = '0;
            m_ctr[i]    = (1 << (CTR_BITS - 1)) - 1;
        end
        m_ghr = 0;
    endtask

    task automatic m_lookup(input logic [63:0] pc, output logic h, output logic t,
                            output logic [63:0] n);
        int unsigned i;
        i = m_index(pc, m_ghr);
        h = m_valid[i] && (m_tag[i] == m_tag_of(pc));
        t = h && (m_ctr[i] >= (1 << (CTR_BITS - 1)));
        n = t ? m_target[i] : pc + 64'd4;
    endtask

    task automatic m_update(input logic [63:0] pc, input logic t, input logic [63:0] tgt,
                            input int unsigned ghr);
        int unsigned i;
        i = m_index(pc, ghr);
        if (m_valid[i] && (m_tag[i] == m_tag_of(pc))) begin
            if (t) begin
                if (m_ctr[i] < (1 << CTR_BITS) - 1) m_ctr[i]++;
                m_target[i] = tgt;
            end else if (m_ctr[i] > 0) begin
                m_ctr[i]--;
            end
        end else if (t) begin
            m_valid[i]  = 1'b1;
            m_tag[i]    = m_tag_of(pc);
            m_target[i] = tgt;
            m_ctr[i]    = 1 << (CTR_BITS - 1);
        end
`ifdef BRANCH_PREDICTOR_GSHARE_EN
        m_ghr = (m_ghr * 2 + int'(t)) % (1 << HIST_BITS);
`endif
    endtask

    // One driven cycle: apply inputs after the edge, queue the expected response,
    // then advance the model as the next edge will.
    task automatic cycle(input logic [63:0] lpc, input logic uv, input logic [63:0] upc,
                         input logic ut, input logic [63:0] utgt, input logic upt,
                         input logic [63:0] uptgt);
        logic h, t, mp;
        logic [63:0] n;
        @(posedge clk);
        #1;
        lkp_pc          = lpc;
        upd_valid       = uv;
        upd_pc          = upc;
        upd_taken       = ut;
        upd_target      = utgt;
        upd_pred_taken  = upt;
        upd_pred_target = uptgt;
        upd_ghr         = HIST_BITS'(m_ghr);
        m_lookup(lpc, h, t, n);
        mp = uv && ((upt != ut) || (ut && (uptgt != utgt)));
        exp_q.push_back({h, t, n, mp, HIST_BITS'(m_ghr)});
        if (uv) m_update(upc, ut, utgt, m_ghr);
    endtask

    task automatic look(input logic [63:0] lpc);
        cycle(lpc, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    endtask

    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("lkp_hit",     64'(lkp_hit),     64'(e[HIST_BITS + 2 + XLEN]));
            check("lkp_taken",   64'(lkp_taken),   64'(e[HIST_BITS + 1 + XLEN]));
            check("lkp_next_pc", lkp_next_pc,      e[HIST_BITS + 1 +: XLEN]);
            check("mispredict",  64'(mispredict),  64'(e[HIST_BITS]));
            check("lkp_ghr",     64'(lkp_ghr),     64'(e[HIST_BITS-1:0]));
        end
    end

    initial begin
        logic [63:0] pc_a, pc_b, tgt, ptgt;
        logic        uv, ut, upt, h, t;
        logic [63:0] n;

        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Reset state, allocation, same-cycle no-bypass and mispredict.
        look(64'h1000);
        cycle(64'h1000, 1'b1, 64'h1000, 1'b1, 64'h0F00, 1'b0, 64'h1004);
        look(64'h1000);

        // Saturation at 0 then at all-ones.
        for (int k = 0; k < 3; k++) cycle(64'h1000, 1'b1, 64'h1000, 1'b0, '0, 1'b1, 64'h0F00);
        look(64'h1000);
        for (int k = 0; k < 4; k++) cycle(64'h1000, 1'b1, 64'h1000, 1'b1, 64'h0F00, 1'b0, 64'h1004);
        look(64'h1000);
        cycle(64'h1000, 1'b1, 64'h1000, 1'b0, '0, 1'b1, 64'h0F00);
        look(64'h1000);

        // Aliasing: same index, different tag.
        look(64'h1100);
        cycle(64'h1100, 1'b1, 64'h1100, 1'b1, 64'h5500, 1'b1, 64'h5500);
        look(64'h1000);
        look(64'h1100);

        // Same-cycle lookup/update of an allocating branch, then gated mispredict.
        cycle(64'h2000, 1'b1, 64'h2000, 1'b1, 64'h6000, 1'b0, 64'h2004);
        look(64'h2000);
        cycle(64'h2000, 1'b0, 64'h2000, 1'b1, 64'h6000, 1'b0, 64'h2004);
        cycle(64'h2000, 1'b1, 64'h2000, 1'b1, 64'h6000, 1'b1, 64'h6004);
        look(64'hFFFF_FFFF_FFFF_FFFC);

        // Randomised traffic over a small aliasing-heavy PC pool.
        for (int k = 0; k < 400; k++) begin
            pc_a = 64'h4000 + 64'($urandom_range(0, 3) << 8) + 64'($urandom_range(0, 7) << 2);
            pc_b = 64'h4000 + 64'($urandom_range(0, 3) << 8) + 64'($urandom_range(0, 7) << 2);
            uv   = ($urandom_range(0, 3) != 0);
            ut   = $urandom_range(0, 1) == 1;
            tgt  = {$urandom(), $urandom()} & ~64'h3;
            if ($urandom_range(0, 1) == 1) begin
                m_lookup(pc_b, h, t, n);
                upt  = t;
                ptgt = ($urandom_range(0, 3) == 0) ? tgt : n;
            end else begin
                upt  = $urandom_range(0, 1) == 1;
                ptgt = {$urandom(), $urandom()} & ~64'h3;
            end
            cycle(pc_a, uv, pc_b, ut, tgt, upt, ptgt);
        end

        // Populate eight entries, then drop reset between clock edges.
        for (int k = 0; k < 8; k++)
            cycle(64'h8000 + 64'(k * 4), 1'b1, 64'h8000 + 64'(k * 4), 1'b1,
                  64'h9000 + 64'(k * 16), 1'b0, '0);
        look(64'h8000);
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        #2;
        reset = 1'b0;
        m_reset();
        for (int k = 0; k < 8; k++) begin
            lkp_pc = 64'h8000 + 64'(k * 4);
            #1;
            check("async_rst_hit",   64'(lkp_hit),   64'd0);
            check("async_rst_taken", 64'(lkp_taken), 64'd0);
            check("async_rst_next",  lkp_next_pc,    64'h8004 + 64'(k * 4));
        end
        check("async_rst_ghr", 64'(lkp_ghr),    64'd0);
        check("async_rst_mp",  64'(mispredict), 64'd0);

        // An update presented while reset is held must not land.
        upd_valid  = 1'b1;
        upd_pc     = 64'h8000;
        upd_taken  = 1'b1;
        upd_target = 64'hABC0;
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        lkp_pc    = 64'h8000;
        #1;
        check("rst_hold_hit", 64'(lkp_hit), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // History: T, N, T then observe the snapshot.
        cycle(64'hA000, 1'b1, 64'hA000, 1'b1, 64'hB000, 1'b1, 64'hB000);
        cycle(64'hA000, 1'b1, 64'hA010, 1'b0, '0, 1'b0, '0);
        cycle(64'hA000, 1'b1, 64'hA020, 1'b1, 64'hC000, 1'b0, '0);
        look(64'hA000);
        @(posedge clk);
        #1;
`ifdef BRANCH_PREDICTOR_GSHARE_EN
        check("ghr_tnt", 64'(lkp_ghr), 64'b000101);
`else
        check("ghr_off", 64'(lkp_ghr), 64'd0);
`endif

        repeat (2) @(posedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
